// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the FFT, FIR and IIR
// accelerators, moving one committed read or write burst at a time.

module ram_arbiter_checker (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] gnt,
    input  logic [2:0] wr_ack,
    input  logic [2:0] rd_valid,
    input  logic [2:0] done,
    input  logic       busy,
    input  logic       ram_read_enable,
    input  logic       ram_write_enable
);

    a_enable_excl: assert property (@(posedge clk) disable iff (!reset)
        !(ram_read_enable && ram_write_enable));
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt));
    a_ack_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(wr_ack));
    a_rdv_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(rd_valid));
    a_done_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(done));
    a_busy_gnt: assert property (@(posedge clk) disable iff (!reset)
        busy == (gnt != 3'b000));

endmodule

module ram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          req,
    input  logic [2:0]          req_we,
    input  logic [3*ADDR_W-1:0] req_addr,
    input  logic [3*LEN_W-1:0]  req_len,
    input  logic [3*DATA_W-1:0] req_wdata,
    output logic [2:0]          gnt,
    output logic [2:0]          wr_ack,
    output logic [2:0]          rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic [2:0]          done,
    output logic                busy,
    output logic                ram_read_enable,
    output logic                ram_write_enable,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [1:0]          owner_r, owner_s;
    logic                we_r, we_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [LEN_W-1:0]    cnt_r, cnt_s;
    logic [1:0]          last_gnt_r, last_gnt_s;
    logic [2:0]          rd_valid_r;
    logic [1:0]          pick_s;

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot3 = 3'b001;
            2'd1:    onehot3 = 3'b010;
            2'd2:    onehot3 = 3'b100;
            default: onehot3 = 3'b000;
        endcase
    endfunction

    // Search order starts just after the previous winner, so the last winner ranks lowest.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        case (last)
            2'd0:    rr_pick = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
            2'd1:    rr_pick = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
            default: rr_pick = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
        endcase
    endfunction

    // State and burst-context registers, plus the one-cycle-delayed read strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            owner_r    <= 2'd0;
            we_r       <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            cnt_r      <= {LEN_W{1'b0}};
            last_gnt_r <= 2'd2;
            rd_valid_r <= 3'b000;
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            we_r       <= we_s;
            addr_r     <= addr_s;
            cnt_r      <= cnt_s;
            last_gnt_r <= last_gnt_s;
            if (state_r == BURST && !we_r) begin
                rd_valid_r <= onehot3(owner_r);
            end else begin
                rd_valid_r <= 3'b000;
            end
        end
    end

    // Next-state: arbitrate and latch the winner's burst in IDLE, walk it in BURST.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        we_s       = we_r;
        addr_s     = addr_r;
        cnt_s      = cnt_r;
        last_gnt_s = last_gnt_r;
        pick_s     = rr_pick(req, last_gnt_r);
        case (state_r)
            IDLE: begin
                if (req != 3'b000) begin
                    owner_s    = pick_s;
                    we_s       = req_we[pick_s];
                    addr_s     = req_addr[int'(pick_s) * ADDR_W +: ADDR_W];
                    cnt_s      = req_len[int'(pick_s) * LEN_W +: LEN_W];
                    last_gnt_s = pick_s;
                    state_s    = BURST;
                end else begin
                    state_s    = IDLE;
                end
            end
            BURST: begin
                addr_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (cnt_r == {LEN_W{1'b0}}) begin
                    state_s = DRAIN;
                end else begin
                    cnt_s   = cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
                end
            end
            DRAIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode of the registered state; write data passes straight from the owner.
    always_comb begin
        gnt              = 3'b000;
        wr_ack           = 3'b000;
        done             = 3'b000;
        busy             = 1'b0;
        ram_read_enable  = 1'b0;
        ram_write_enable = 1'b0;
        ram_addr         = {ADDR_W{1'b0}};
        ram_wdata        = {DATA_W{1'b0}};
        if (state_r != IDLE) begin
            gnt  = onehot3(owner_r);
            busy = 1'b1;
        end else begin
            gnt  = 3'b000;
            busy = 1'b0;
        end
        case (state_r)
            BURST: begin
                ram_addr = addr_r;
                if (we_r) begin
                    ram_write_enable = 1'b1;
                    ram_wdata        = req_wdata[int'(owner_r) * DATA_W +: DATA_W];
                    wr_ack           = onehot3(owner_r);
                end else begin
                    ram_read_enable  = 1'b1;
                end
            end
            DRAIN: begin
                done = onehot3(owner_r);
            end
            default: begin
                done = 3'b000;
            end
        endcase
    end

    // Read return: RAM data is only forwarded in the cycle its strobe is raised.
    always_comb begin
        rd_valid = rd_valid_r;
        if (rd_valid_r != 3'b000) begin
            rd_data = ram_rdata;
        end else begin
            rd_data = {DATA_W{1'b0}};
        end
    end

    ram_arbiter_checker u_checker (
        .clk              (clk),
        .reset            (reset),
        .gnt              (gnt),
        .wr_ack           (wr_ack),
        .rd_valid         (rd_valid),
        .done             (done),
        .busy             (busy),
        .ram_read_enable  (ram_read_enable),
        .ram_write_enable (ram_write_enable)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a behavioural RAM, per-requester drivers, and
// queues of expected RAM beats, read returns and done pulses with their exact cycles.

module tb_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [2:0]     req, req_we;
    logic [3*AW-1:0] req_addr;
    logic [3*LW-1:0] req_len;
    logic [3*DW-1:0] req_wdata;
    logic [2:0]     gnt, wr_ack, rd_valid, done;
    logic [DW-1:0]  rd_data, ram_wdata, ram_rdata;
    logic           busy, ram_read_enable, ram_write_enable;
    logic [AW-1:0]  ram_addr;

    typedef struct {
        int         cyc;
        logic       we;
        logic [9:0] addr;
        logic [31:0] data;
        logic [1:0] own;
    } op_t;

    op_t op_q[$];
    op_t rd_q[$];
    op_t done_q[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          served[3] = '{0, 0, 0};
    int          limit[3];
    logic [2:0]  want;
    logic        preload;
    logic [31:0] wbase[3];
    logic [31:0] wbeat[3];
    logic [31:0] mem[1024];
    logic [31:0] exp_mem[1024];

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_len          (req_len),
        .req_wdata        (req_wdata),
        .gnt              (gnt),
        .wr_ack           (wr_ack),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .done             (done),
        .busy             (busy),
        .ram_read_enable  (ram_read_enable),
        .ram_write_enable (ram_write_enable),
        .ram_addr         (ram_addr),
        .ram_wdata        (ram_wdata),
        .ram_rdata        (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A requester keeps asking until it has been served the number of bursts it wants.
    assign req[0] = want[0] && (served[0] < limit[0]);
    assign req[1] = want[1] && (served[1] < limit[1]);
    assign req[2] = want[2] && (served[2] < limit[2]);
    assign req_wdata = {wbase[2] + wbeat[2], wbase[1] + wbeat[1], wbase[0] + wbeat[0]};

    function automatic logic [31:0] pattern(input int i);
        pattern = 32'hA500_0000 ^ 32'(i);
    endfunction

    function automatic logic [2:0] oh(input logic [1:0] i);
        oh = 3'b001 << i;
    endfunction

    // RAM with one-cycle read latency; data is junk unless a read was issued.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pattern(i);
        end else begin
            if (ram_write_enable) mem[ram_addr] <= ram_wdata;
        end
        if (ram_read_enable) ram_rdata <= mem[ram_addr];
        else                 ram_rdata <= 32'hDEAD_BEEF;
    end

    // Each requester moves to its next write word after a cycle with wr_ack.
    initial begin
        logic [2:0] a;
        for (int i = 0; i < 3; i++) wbeat[i] = 32'd0;
        forever begin
            @(negedge clk);
            a = wr_ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) if (a[i]) wbeat[i] = wbeat[i] + 32'd1;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: pop expectations as the DUT produces RAM beats, read returns and done pulses.
    always @(negedge clk) begin
        op_t e;
        if (ram_read_enable || ram_write_enable) begin
            check("en_excl", 64'(ram_read_enable & ram_write_enable), 64'd0);
            if (op_q.size() == 0) begin
                check("op_unexpected", 64'd1, 64'd0);
            end else begin
                e = op_q.pop_front();
                check("op_cycle", 64'(cyc), 64'(e.cyc));
                check("op_we", 64'(ram_write_enable), 64'(e.we));
                check("op_addr", 64'(ram_addr), 64'(e.addr));
                check("op_gnt", 64'(gnt), 64'(oh(e.own)));
                check("op_busy", 64'(busy), 64'd1);
                if (e.we) begin
                    check("wr_data", 64'(ram_wdata), 64'(e.data));
                    check("wr_ack", 64'(wr_ack), 64'(oh(e.own)));
                end else begin
                    check("rd_no_ack", 64'(wr_ack), 64'd0);
                end
            end
        end else if (wr_ack != 3'b000) begin
            check("ack_stray", 64'(wr_ack), 64'd0);
        end
        if (rd_valid != 3'b000) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 64'(rd_valid), 64'd0);
            end else begin
                e = rd_q.pop_front();
                check("rd_cycle", 64'(cyc), 64'(e.cyc));
                check("rd_valid", 64'(rd_valid), 64'(oh(e.own)));
                check("rd_data", 64'(rd_data), 64'(e.data));
            end
        end
        if (done != 3'b000) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 64'(done), 64'd0);
            end else begin
                e = done_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("done_owner", 64'(done), 64'(oh(e.own)));
                check("done_gnt", 64'(gnt), 64'(oh(e.own)));
                check("done_busy", 64'(busy), 64'd1);
            end
            for (int i = 0; i < 3; i++) if (done[i]) served[i] = served[i] + 1;
        end
    end

    // Expected beats of one burst whose arbitration happens in cycle idle; stop limits the beats.
    task automatic plan(input int idle, input logic [1:0] own, input logic we,
                        input logic [9:0] addr, input int len, input int stop,
                        output int next_idle);
        op_t e;
        for (int k = 0; k <= len && k < stop; k++) begin
            e.own  = own;
            e.we   = we;
            e.addr = addr + 10'(k);
            e.cyc  = idle + 1 + k;
            if (we) begin
                e.data = wbase[own] + wbeat[own] + 32'(k);
                exp_mem[e.addr] = e.data;
                op_q.push_back(e);
            end else begin
                e.data = exp_mem[e.addr];
                op_q.push_back(e);
                e.cyc = idle + 2 + k;
                rd_q.push_back(e);
            end
        end
        if (stop > len) begin
            e.cyc = idle + 2 + len;
            e.own = own;
            done_q.push_back(e);
        end
        next_idle = idle + 3 + len;
    endtask

    task automatic set_req(input int own, input logic we, input logic [9:0] addr,
                           input logic [3:0] len, input int bursts);
        req_we[own]             = we;
        req_addr[own*AW +: AW]  = addr;
        req_len[own*LW +: LW]   = len;
        limit[own]              = served[own] + bursts;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((op_q.size() + rd_q.size() + done_q.size()) != 0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        check("drain_timeout", 64'(op_q.size() + rd_q.size() + done_q.size()), 64'd0);
        op_q.delete();
        rd_q.delete();
        done_q.delete();
        want = 3'b000;
        repeat (3) @(posedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"}, 64'(gnt), 64'd0);
        check({tag, "_wr_ack"}, 64'(wr_ack), 64'd0);
        check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_ram_re"}, 64'(ram_read_enable), 64'd0);
        check({tag, "_ram_we"}, 64'(ram_write_enable), 64'd0);
        check({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
        check({tag, "_ram_wdata"}, 64'(ram_wdata), 64'd0);
        check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b0;
        preload   = 1'b1;
        want      = 3'b000;
        req_we    = 3'b000;
        req_addr  = '0;
        req_len   = '0;
        wbase[0]  = 32'h0F0F_0000;
        wbase[1]  = 32'hF1F1_0000;
        wbase[2]  = 32'hCC00_0000;
        for (int i = 0; i < 3; i++) limit[i] = 0;
        for (int i = 0; i < 1024; i++) exp_mem[i] = pattern(i);
        @(posedge clk);
        #1 preload = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) check_quiet("reset");
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // Single FFT read of four beats.
        @(posedge clk);
        #1 n = cyc;
        set_req(0, 1'b0, 10'h010, 4'd3, 1);
        want = 3'b001;
        plan(n, 2'd0, 1'b0, 10'h010, 3, 99, n);
        wait_drain();

        // FIR write that wraps the address, then read it back through FFT.
        @(posedge clk);
        #1 n = cyc;
        set_req(1, 1'b1, 10'h3FE, 4'd2, 1);
        want = 3'b010;
        plan(n, 2'd1, 1'b1, 10'h3FE, 2, 99, n);
        wait_drain();
        @(posedge clk);
        #1 n = cyc;
        set_req(0, 1'b0, 10'h3FE, 4'd2, 1);
        want = 3'b001;
        plan(n, 2'd0, 1'b0, 10'h3FE, 2, 99, n);
        wait_drain();

        // Single-beat IIR read.
        @(posedge clk);
        #1 n = cyc;
        set_req(2, 1'b0, 10'h3FF, 4'd0, 1);
        want = 3'b100;
        plan(n, 2'd2, 1'b0, 10'h3FF, 0, 99, n);
        wait_drain();

        // Round robin with all three held; FIR leaves after one burst.
        @(posedge clk);
        #1 n = cyc;
        set_req(0, 1'b0, 10'h100, 4'd1, 3);
        set_req(1, 1'b0, 10'h200, 4'd0, 1);
        set_req(2, 1'b0, 10'h300, 4'd2, 2);
        want = 3'b111;
        plan(n, 2'd0, 1'b0, 10'h100, 1, 99, n);
        plan(n, 2'd1, 1'b0, 10'h200, 0, 99, n);
        plan(n, 2'd2, 1'b0, 10'h300, 2, 99, n);
        plan(n, 2'd0, 1'b0, 10'h100, 1, 99, n);
        plan(n, 2'd2, 1'b0, 10'h300, 2, 99, n);
        plan(n, 2'd0, 1'b0, 10'h100, 1, 99, n);
        wait_drain();

        // FIR drops req and scrambles its fields mid-burst; the burst still completes.
        @(posedge clk);
        #1 n = cyc;
        set_req(1, 1'b0, 10'h040, 4'd7, 1);
        want = 3'b010;
        plan(n, 2'd1, 1'b0, 10'h040, 7, 99, n);
        repeat (2) @(posedge clk);
        #1 want = 3'b000;
        req_we[1] = 1'b1;
        req_addr[1*AW +: AW] = 10'h155;
        req_len[1*LW +: LW] = 4'd0;
        wait_drain();

        // Reset during beat 2 of an FFT write: three beats land, no done follows.
        @(posedge clk);
        #1 n = cyc;
        set_req(0, 1'b1, 10'h080, 4'd5, 1);
        want = 3'b001;
        plan(n, 2'd0, 1'b1, 10'h080, 5, 3, n);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        want = 3'b000;
        @(posedge clk);
        @(negedge clk) check_quiet("rst_mid");
        @(posedge clk);
        #1 reset = 1'b1;
        wait_drain();

        // Simultaneous requests after reset: FFT first, then FIR, then IIR.
        @(posedge clk);
        #1 n = cyc;
        set_req(0, 1'b0, 10'h080, 4'd2, 1);
        set_req(1, 1'b0, 10'h081, 4'd0, 1);
        set_req(2, 1'b1, 10'h300, 4'd1, 1);
        want = 3'b111;
        plan(n, 2'd0, 1'b0, 10'h080, 2, 99, n);
        plan(n, 2'd1, 1'b0, 10'h081, 0, 99, n);
        plan(n, 2'd2, 1'b1, 10'h300, 1, 99, n);
        wait_drain();

        @(negedge clk) check_quiet("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
